mac_operand_feeder: RTL and testbench



---
 rtl/mac_pkg.sv | 19 +
 rtl/operand_fifo.sv | 81 ++++++++
 rtl/mac_operand_feeder.sv | 134 +++++++++++++
 tb/tb_mac_operand_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_pkg: state encoding and default sizes shared by the MAC feeder.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_e;

  localparam int unsigned MAC_DATA_W  = 2;
  localparam int unsigned MAC_VEC_LEN = 4;

endpackage
`default_nettype wire

// File: rtl/operand_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_fifo: synchronous FIFO, registered full/empty, flush input.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module operand_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  always_comb begin
    do_push  = push && !full_q && !flush;
    do_pop   = pop && !empty_q && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule
`default_nettype wire

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_operand_feeder: buffers operand pairs and streams VEC_LEN-long   |
// | dot products into the MAC, flagging each finished result. Rev 1.0    |
// +----------------------------------------------------------------------+
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = MAC_DATA_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned VEC_LEN = MAC_VEC_LEN,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              abort,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_e,
  output logic              result_valid,
  output logic              busy
);

  localparam int unsigned ISSUE_W = $clog2(VEC_LEN + 1);
  localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  feed_state_e         state_q, state_d;
  logic [ISSUE_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [DATA_W-1:0]   mac_a_q, mac_a_d;
  logic [DATA_W-1:0]   mac_b_q, mac_b_d;
  logic                mac_e_q, mac_e_d;
  logic                result_valid_q, result_valid_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rd;

  // Abort flushes the FIFO and beats any push in the same cycle.
  assign fifo_push = in_valid && !abort;

  operand_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .push    (fifo_push),
    .wr_data ({in_a, in_b}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    fifo_pop    = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      issue_cnt_d = '0;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          issue_cnt_d = '0;
          drain_cnt_d = '0;
          if (!fifo_empty) state_d = FEED;
        end
        FEED: begin
          // An empty FIFO leaves zero operands on the MAC: a harmless bubble.
          if (!fifo_empty) begin
            fifo_pop           = 1'b1;
            {mac_a_d, mac_b_d} = fifo_rd;
            issue_cnt_d        = issue_cnt_q + ISSUE_W'(1);
            if (issue_cnt_d == ISSUE_W'(VEC_LEN)) begin
              state_d     = DRAIN;
              drain_cnt_d = '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_W'(MAC_LAT - 1)) begin
            state_d     = DONE;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    mac_e_d        = (state_d == IDLE);
    result_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      issue_cnt_q    <= '0;
      drain_cnt_q    <= '0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      mac_e_q        <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      issue_cnt_q    <= issue_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      mac_a_q        <= mac_a_d;
      mac_b_q        <= mac_b_d;
      mac_e_q        <= mac_e_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign in_ready     = !fifo_full;
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign mac_e        = mac_e_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_operand_feeder: directed vectors against a behavioural MAC.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mac_operand_feeder;

  localparam int unsigned DATA_W  = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned VEC_LEN = 4;
  localparam int unsigned MAC_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic              abort;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic              mac_e;
  logic              result_valid;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] acc = 8'd0;
  logic [3:0] obs[$];

  typedef struct {
    logic [3:0][1:0] a;
    logic [3:0][1:0] b;
    int              gap;
    int              exp_sum;
    int              exp_lat;
  } vec_t;

  vec_t tbl[5];

  mac_operand_feeder #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .VEC_LEN (VEC_LEN),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .abort        (abort),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_e        (mac_e),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Single-cycle MAC: accumulator cleared while E=1, else adds a*b each edge.
  always @(posedge clk) begin
    if (mac_e) acc <= 8'd0;
    else       acc <= acc + 8'(mac_a) * 8'(mac_b);
  end

  always @(negedge clk) begin
    if (rst_n && !mac_e && (mac_a != 0 || mac_b != 0)) obs.push_back({mac_a, mac_b});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3, gap, sum, lat);
    vec_t v;
    v.a[0] = 2'(a0); v.a[1] = 2'(a1); v.a[2] = 2'(a2); v.a[3] = 2'(a3);
    v.b[0] = 2'(b0); v.b[1] = 2'(b1); v.b[2] = 2'(b2); v.b[3] = 2'(b3);
    v.gap = gap; v.exp_sum = sum; v.exp_lat = lat;
    return v;
  endfunction

  // Pairs 0,1 go on iterations 0,1; pairs 2,3 follow after `gap` idle cycles.
  // Latency counts edges from the first push edge to the edge raising result_valid.
  task automatic run_vector(input vec_t v, input string tag);
    int rv_at = -1;
    int rv_n  = 0;
    obs.delete();
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b0; in_a = '0; in_b = '0;
      for (int i = 0; i < 4; i++) begin
        if (i + ((i >= 2) ? v.gap : 0) == c) begin
          in_valid = 1'b1; in_a = v.a[i]; in_b = v.b[i];
        end
      end
      @(negedge clk);
      if (result_valid) begin
        rv_n++;
        if (rv_at < 0) begin
          rv_at = c;
          check({tag, " sum"}, acc, v.exp_sum);
        end
      end
      @(posedge clk); #1;
      if (rv_at >= 0 && c >= rv_at + 2) break;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, rv_at - 1, v.exp_lat);
    check({tag, " pulse count"}, rv_n, 1);
    check({tag, " issued pairs"}, obs.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs.size()) check({tag, " pair order"}, obs[i], {v.a[i], v.b[i]});
    @(negedge clk);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle mac_e"}, mac_e, 1);
    @(posedge clk); #1;
  endtask

  task automatic full_and_back_to_back();
    logic [3:0] pairs[12];
    int         sums[3];
    int         idx = 0;
    int         k   = 0;
    logic       hs;
    logic       exp_ready, exp_e, exp_rv;
    pairs = '{4'h5, 4'h6, 4'h9, 4'h7, 4'hA, 4'h5, 4'hD, 4'h6, 4'hE, 4'hA, 4'h5, 4'hD};
    sums  = '{8, 10, 14};
    obs.delete();
    for (int c = 0; c < 26; c++) begin
      in_valid = (idx < 12);
      in_a     = (idx < 12) ? pairs[idx][3:2] : '0;
      in_b     = (idx < 12) ? pairs[idx][1:0] : '0;
      @(negedge clk);
      exp_ready = !(c == 8 || c == 9 || c == 14 || c == 15 || c == 16);
      exp_e     = (c <= 1 || c == 8 || c == 15 || c >= 22);
      exp_rv    = (c == 7 || c == 14 || c == 21);
      check("b2b in_ready", in_ready, exp_ready);
      check("b2b mac_e", mac_e, exp_e);
      check("b2b result_valid", result_valid, exp_rv);
      if (result_valid && k < 3) begin
        check("b2b sum", acc, sums[k]);
        k++;
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    check("b2b accepted pairs", idx, 12);
    check("b2b issued pairs", obs.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < obs.size()) check("b2b pair order", obs[i], pairs[i]);
  endtask

  task automatic abort_mid_feed();
    logic [3:0] pairs[5];
    int         rv_n = 0;
    pairs = '{4'h5, 4'h6, 4'h9, 4'h0, 4'hF};
    obs.delete();
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 3 || c == 4);
      in_a     = (c < 5) ? pairs[c][3:2] : '0;
      in_b     = (c < 5) ? pairs[c][1:0] : '0;
      abort    = (c == 4);
      @(negedge clk);
      if (result_valid) rv_n++;
      if (c == 4) check("abort pre busy", busy, 1);
      if (c == 5) begin
        check("abort busy", busy, 0);
        check("abort mac_e", mac_e, 1);
        check("abort mac_a", mac_a, 0);
        check("abort mac_b", mac_b, 0);
        check("abort in_ready", in_ready, 1);
      end
      if (c > 5) check("abort fifo empty (stays idle)", busy, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; abort = 1'b0;
    check("abort result_valid pulses", rv_n, 0);
    check("abort issued pairs", obs.size(), 2);
  endtask

  task automatic reset_mid_drain(input vec_t v);
    int rv_n = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 4);
      in_a     = (c < 4) ? v.a[c] : '0;
      in_b     = (c < 4) ? v.b[c] : '0;
      if (c == 6) begin
        rst_n = 1'b0; in_valid = 1'b1; in_a = 2'd3; in_b = 2'd3;
      end
      @(negedge clk);
      if (c == 6) check("reset pre busy (drain)", busy, 1);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    @(negedge clk);
    check("reset mac_a", mac_a, 0);
    check("reset mac_b", mac_b, 0);
    check("reset mac_e", mac_e, 1);
    check("reset result_valid", result_valid, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 1);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (result_valid) rv_n++;
      check("reset push dropped (stays idle)", busy, 0);
      @(posedge clk); #1;
    end
    check("reset result_valid pulses", rv_n, 0);
  endtask

  initial begin
    tbl[0] = mk(1, 1, 2, 1, 1, 2, 1, 3, 0, 8, 6);
    tbl[1] = mk(1, 1, 2, 1, 1, 2, 1, 3, 2, 8, 7);
    tbl[2] = mk(1, 1, 2, 1, 1, 2, 1, 3, 3, 8, 8);
    tbl[3] = mk(3, 3, 3, 3, 3, 3, 3, 3, 0, 36, 6);
    tbl[4] = mk(2, 3, 1, 2, 3, 1, 1, 2, 1, 14, 6);

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst mac_a", mac_a, 0);
    check("rst mac_b", mac_b, 0);
    check("rst mac_e", mac_e, 1);
    check("rst result_valid", result_valid, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) run_vector(tbl[t], $sformatf("vec%0d", t));

    full_and_back_to_back();
    abort_mid_feed();
    run_vector(tbl[0], "post-abort");
    reset_mid_drain(tbl[0]);
    run_vector(tbl[4], "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
